// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the data-memory port arbiter.
//   size_e  - request access size codes (byte/half/word/illegal)
//   DMOP_*  - lane codes understood by the single-port data memory
//   state_e - arbiter FSM states
package dm_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    localparam logic [2:0] DMOP_WORD = 3'b000;
    localparam logic [2:0] DMOP_HLO  = 3'b001;
    localparam logic [2:0] DMOP_HHI  = 3'b010;
    localparam logic [2:0] DMOP_B0   = 3'b011;
    localparam logic [2:0] DMOP_B1   = 3'b100;
    localparam logic [2:0] DMOP_B2   = 3'b101;
    localparam logic [2:0] DMOP_B3   = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

endpackage

// File: rtl/dm_lane_fmt.sv
// dm_lane_fmt: combinational lane decode and load-data formatting.
//   addr_lo - byte offset within the word
//   size    - access size
//   sgn     - sign-extend byte/half loads
//   dout    - raw memory read word
//   dmop    - memory lane code
//   err     - misaligned or illegal size
//   rdata   - lane-selected, extended load data
module dm_lane_fmt
    import dm_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  size_e       size,
    input  logic        sgn,
    input  logic [31:0] dout,
    output logic [2:0]  dmop,
    output logic        err,
    output logic [31:0] rdata
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        dmop   = DMOP_WORD;
        err    = 1'b0;
        rdata  = '0;
        byte_v = '0;
        half_v = '0;
        case (size)
            SZ_BYTE: begin
                // byte lane codes are contiguous, so offset the base code
                dmop   = DMOP_B0 + {1'b0, addr_lo};
                byte_v = dout[{addr_lo, 3'b000} +: 8];
                rdata  = {{24{sgn & byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                dmop   = addr_lo[1] ? DMOP_HHI : DMOP_HLO;
                half_v = addr_lo[1] ? dout[31:16] : dout[15:0];
                rdata  = {{16{sgn & half_v[15]}}, half_v};
                err    = addr_lo[0];
            end
            SZ_WORD: begin
                dmop  = DMOP_WORD;
                rdata = dout;
                err   = |addr_lo;
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: two-port round-robin front end for the 4 KB data memory.
//   clk, rst            - clock, async active-high reset
//   pN_req/we/addr/size/sgn/wdata - port N request (held until ack)
//   pN_ack/err/rdata    - port N completion pulse, error flag, load data
//   dm_addr/din/we/dmop - memory control, driven only during ACCESS
//   dm_dout             - memory read data (combinational from dm_addr)
// Each access takes IDLE -> ACCESS -> DONE; the ack lands in DONE.
module dm_port_arbiter
    import dm_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [1:0]    p0_size,
    input  logic          p0_sgn,
    input  logic [31:0]   p0_wdata,
    output logic          p0_ack,
    output logic          p0_err,
    output logic [31:0]   p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [1:0]    p1_size,
    input  logic          p1_sgn,
    input  logic [31:0]   p1_wdata,
    output logic          p1_ack,
    output logic          p1_err,
    output logic [31:0]   p1_rdata,
    output logic [AW-3:0] dm_addr,
    output logic [31:0]   dm_din,
    output logic          dm_we,
    output logic [2:0]    dm_dmop,
    input  logic [31:0]   dm_dout
);

    state_e        state_q, state_d;
    logic          last_q;    // port granted most recently
    logic          gnt_q;     // port owning the current access
    logic          grant, win;
    logic          lat_we, lat_sgn;
    logic [AW-1:0] lat_addr;
    size_e         lat_size;
    logic [31:0]   lat_wdata;
    logic [31:0]   rd0_q, rd1_q;
    logic [2:0]    f_dmop;
    logic          f_err;
    logic [31:0]   f_rdata;
    logic [31:0]   ld_val;

    // err depends only on latched addr/size, so it is stable from the
    // grant edge through DONE.
    dm_lane_fmt u_fmt (
        .addr_lo (lat_addr[1:0]),
        .size    (lat_size),
        .sgn     (lat_sgn),
        .dout    (dm_dout),
        .dmop    (f_dmop),
        .err     (f_err),
        .rdata   (f_rdata)
    );

    assign ld_val   = (lat_we | f_err) ? 32'h0 : f_rdata;
    assign p0_rdata = rd0_q;
    assign p1_rdata = rd1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        win     = 1'b0;
        dm_addr = '0;
        dm_din  = '0;
        dm_we   = 1'b0;
        dm_dmop = DMOP_WORD;
        p0_ack  = 1'b0;
        p1_ack  = 1'b0;
        p0_err  = 1'b0;
        p1_err  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (p0_req | p1_req) begin
                    grant   = 1'b1;
                    // p1 wins when alone, or on a tie when p0 went last
                    win     = p1_req & (~p0_req | ~last_q);
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                dm_addr = lat_addr[AW-1:2];
                dm_din  = lat_wdata;
                dm_dmop = f_dmop;
                dm_we   = lat_we & ~f_err;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                p0_ack  = ~gnt_q;
                p1_ack  = gnt_q;
                p0_err  = ~gnt_q & f_err;
                p1_err  = gnt_q & f_err;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            lat_we    <= 1'b0;
            lat_sgn   <= 1'b0;
            lat_addr  <= '0;
            lat_size  <= SZ_BYTE;
            lat_wdata <= '0;
            rd0_q     <= '0;
            rd1_q     <= '0;
        end else begin
            if (grant) begin
                gnt_q     <= win;
                last_q    <= win;
                lat_we    <= win ? p1_we    : p0_we;
                lat_sgn   <= win ? p1_sgn   : p0_sgn;
                lat_addr  <= win ? p1_addr  : p0_addr;
                lat_size  <= win ? size_e'(p1_size) : size_e'(p0_size);
                lat_wdata <= win ? p1_wdata : p0_wdata;
            end
            if (state_q == ST_ACCESS) begin
                if (gnt_q) rd1_q <= ld_val;
                else       rd0_q <= ld_val;
            end
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0;
    logic [1:0]  we  = '0;
    logic [1:0]  sgn = '0;
    logic [11:0] addr  [2];
    logic [1:0]  size  [2];
    logic [31:0] wdata [2];

    logic        p0_ack, p1_ack, p0_err, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [9:0]  dm_addr;
    logic [31:0] dm_din, dm_dout;
    logic        dm_we;
    logic [2:0]  dm_dmop;

    logic [1:0]  ack_v, err_v;
    logic [31:0] rd_v [2];
    assign ack_v = {p1_ack, p0_ack};
    assign err_v = {p1_err, p0_err};
    assign rd_v[0] = p0_rdata;
    assign rd_v[1] = p1_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dm_port_arbiter #(.AW(12)) dut (
        .clk(clk), .rst(rst),
        .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_size(size[0]),
        .p0_sgn(sgn[0]), .p0_wdata(wdata[0]), .p0_ack(p0_ack), .p0_err(p0_err),
        .p0_rdata(p0_rdata),
        .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_size(size[1]),
        .p1_sgn(sgn[1]), .p1_wdata(wdata[1]), .p1_ack(p1_ack), .p1_err(p1_err),
        .p1_rdata(p1_rdata),
        .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_dmop(dm_dmop),
        .dm_dout(dm_dout)
    );

    // memory harness standing in for dm_4k
    logic [31:0] mem [0:1023];
    assign dm_dout = mem[dm_addr];
    always @(posedge clk) begin
        if (dm_we) begin
            case (dm_dmop)
                3'd0: mem[dm_addr]        <= dm_din;
                3'd1: mem[dm_addr][15:0]  <= dm_din[15:0];
                3'd2: mem[dm_addr][31:16] <= dm_din[15:0];
                3'd3: mem[dm_addr][7:0]   <= dm_din[7:0];
                3'd4: mem[dm_addr][15:8]  <= dm_din[7:0];
                3'd5: mem[dm_addr][23:16] <= dm_din[7:0];
                3'd6: mem[dm_addr][31:24] <= dm_din[7:0];
                default: ;
            endcase
        end
    end

    // ---------------- reference model: byte-addressed memory + timeline
    logic [7:0]  rmem [0:4095];
    int          ph = 0;       // 0 waiting, 1 memory cycle, 2 completion cycle
    int          mport = 0;
    int          mlast = 1;
    logic        mwe = 1'b0, msgn = 1'b0, merr = 1'b0;
    logic [11:0] maddr = '0;
    logic [1:0]  msize = '0;
    logic [31:0] mwdata = '0;
    logic [31:0] m_rdata [2];

    function automatic int pick(logic [1:0] r, int l);
        if (r[0] && r[1]) return (l == 1) ? 0 : 1;
        return r[0] ? 0 : 1;
    endfunction

    function automatic logic rule_err(logic [11:0] a, logic [1:0] s);
        return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] model_load(logic [11:0] a, logic [1:0] s, logic sg);
        logic [31:0] v;
        v = '0;
        case (s)
            2'd0: v = {{24{sg & rmem[a][7]}}, rmem[a]};
            2'd1: v = {{16{sg & rmem[a+12'd1][7]}}, rmem[a+12'd1], rmem[a]};
            2'd2: v = {rmem[a+12'd3], rmem[a+12'd2], rmem[a+12'd1], rmem[a]};
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [2:0] exp_dmop(logic [11:0] a, logic [1:0] s);
        if (s == 2'd2) return 3'd0;
        if (s == 2'd1) return a[1] ? 3'd2 : 3'd1;
        return 3'd3 + {1'b0, a[1:0]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph         <= 0;
            mlast      <= 1;
            m_rdata[0] <= '0;
            m_rdata[1] <= '0;
        end else begin
            case (ph)
                0: if (req != 2'b00) begin
                    mport  <= pick(req, mlast);
                    mlast  <= pick(req, mlast);
                    mwe    <= we[pick(req, mlast)];
                    msgn   <= sgn[pick(req, mlast)];
                    maddr  <= addr[pick(req, mlast)];
                    msize  <= size[pick(req, mlast)];
                    mwdata <= wdata[pick(req, mlast)];
                    merr   <= rule_err(addr[pick(req, mlast)], size[pick(req, mlast)]);
                    ph     <= 1;
                end
                1: begin
                    if (mwe && !merr) begin
                        case (msize)
                            2'd0: rmem[maddr] <= mwdata[7:0];
                            2'd1: begin
                                rmem[maddr]        <= mwdata[7:0];
                                rmem[maddr+12'd1]  <= mwdata[15:8];
                            end
                            default: begin
                                rmem[maddr]        <= mwdata[7:0];
                                rmem[maddr+12'd1]  <= mwdata[15:8];
                                rmem[maddr+12'd2]  <= mwdata[23:16];
                                rmem[maddr+12'd3]  <= mwdata[31:24];
                            end
                        endcase
                    end
                    m_rdata[mport] <= (mwe || merr) ? 32'h0 : model_load(maddr, msize, msgn);
                    ph <= 2;
                end
                default: ph <= 0;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("p%0d_ack", p), {31'b0, ack_v[p]}, {31'b0, (ph == 2 && mport == p)});
                if (ph == 2 && mport == p)
                    chk($sformatf("p%0d_err", p), {31'b0, err_v[p]}, {31'b0, merr});
                chk($sformatf("p%0d_rdata", p), rd_v[p], m_rdata[p]);
            end
            chk("dm_we", {31'b0, dm_we}, {31'b0, (ph == 1 && mwe && !merr)});
            if (ph == 1) begin
                chk("dm_addr", {22'b0, dm_addr}, {22'b0, maddr[11:2]});
                chk("dm_din", dm_din, mwdata);
                if (!merr) chk("dm_dmop", {29'b0, dm_dmop}, {29'b0, exp_dmop(maddr, msize)});
            end
        end
    end

    task automatic do_req(input int p, input logic w, input logic [11:0] a,
                          input logic [1:0] s, input logic sg, input logic [31:0] wd,
                          output logic e_seen);
        int  n;
        logic got;
        n = 0; got = 1'b0; e_seen = 1'b0;
        @(posedge clk); #2;
        we[p] = w; addr[p] = a; size[p] = s; sgn[p] = sg; wdata[p] = wd; req[p] = 1'b1;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (ack_v[p]) begin got = 1'b1; e_seen = err_v[p]; end
        end
        chk($sformatf("p%0d_ack_timeout", p), {31'b0, got}, 32'd1);
        @(posedge clk); #2;
        req[p] = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},   {30'b0, ack_v}, 32'd0);
        chk({tag, "_err"},   {30'b0, err_v}, 32'd0);
        chk({tag, "_rd0"},   p0_rdata, 32'd0);
        chk({tag, "_rd1"},   p1_rdata, 32'd0);
        chk({tag, "_addr"},  {22'b0, dm_addr}, 32'd0);
        chk({tag, "_din"},   dm_din, 32'd0);
        chk({tag, "_we"},    {31'b0, dm_we}, 32'd0);
        chk({tag, "_dmop"},  {29'b0, dm_dmop}, 32'd0);
    endtask

    initial begin
        logic e;
        int   n, k, cyc;
        int   ack_port [4];
        int   ack_cyc  [4];

        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 4096; i++) rmem[i] = '0;
        mem[2] = 32'h11223344;
        rmem[8] = 8'h44; rmem[9] = 8'h33; rmem[10] = 8'h22; rmem[11] = 8'h11;
        mem[4] = 32'h0000BBCC;
        rmem[16] = 8'hCC; rmem[17] = 8'hBB;
        for (int p = 0; p < 2; p++) begin
            addr[p] = '0; size[p] = '0; wdata[p] = '0;
        end

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #2;
        rst = 1'b0;

        // byte store A5 at 0x013, then loads of the same bytes
        do_req(0, 1'b1, 12'h013, 2'd0, 1'b0, 32'h000000A5, e);
        chk("st_b_err", {31'b0, e}, 32'd0);
        chk("st_b_mem", mem[4], 32'hA500BBCC);
        do_req(0, 1'b0, 12'h013, 2'd0, 1'b1, 32'h0, e);
        chk("ld_b_sgn", p0_rdata, 32'hFFFFFFA5);
        do_req(0, 1'b0, 12'h013, 2'd0, 1'b0, 32'h0, e);
        chk("ld_b_uns", p0_rdata, 32'h000000A5);
        do_req(0, 1'b0, 12'h012, 2'd1, 1'b0, 32'h0, e);
        chk("ld_h_uns", p0_rdata, 32'h0000A500);
        do_req(0, 1'b0, 12'h010, 2'd1, 1'b1, 32'h0, e);
        chk("ld_h_sgn", p0_rdata, 32'hFFFFBBCC);

        // both ports hold req from reset: strict alternation starting at p0
        @(posedge clk); #2;
        rst = 1'b1; #1 rst = 1'b0;
        we = 2'b00; sgn = 2'b10;
        addr[0] = 12'h010; size[0] = 2'd2;
        addr[1] = 12'h008; size[1] = 2'd0;
        req = 2'b11;
        k = 0; cyc = 0;
        while (k < 4 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            chk("no_dual_ack", {31'b0, (ack_v == 2'b11)}, 32'd0);
            if (ack_v != 2'b00) begin
                ack_port[k] = ack_v[1] ? 1 : 0;
                ack_cyc[k]  = cyc;
                k++;
            end
        end
        @(posedge clk); #2;
        req = 2'b00;
        chk("alt_count", k, 32'd4);
        if (k == 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("alt_port%0d", i), ack_port[i], i % 2);
            for (int i = 1; i < 4; i++) chk($sformatf("alt_gap%0d", i), ack_cyc[i] - ack_cyc[i-1], 32'd3);
        end
        chk("alt_rd0", p0_rdata, 32'hA500BBCC);
        chk("alt_rd1", p1_rdata, 32'h00000044);

        // error cases on p1
        do_req(1, 1'b1, 12'h005, 2'd1, 1'b0, 32'h00001234, e);
        chk("err_half_mis", {31'b0, e}, 32'd1);
        chk("err_half_mem", mem[1], 32'h0);
        do_req(1, 1'b0, 12'h006, 2'd2, 1'b0, 32'h0, e);
        chk("err_word_mis", {31'b0, e}, 32'd1);
        chk("err_word_rd", p1_rdata, 32'h0);
        do_req(1, 1'b0, 12'h004, 2'd3, 1'b0, 32'h0, e);
        chk("err_size11", {31'b0, e}, 32'd1);

        // reset during a store's memory cycle
        @(posedge clk); #2;
        we[1] = 1'b1; addr[1] = 12'h008; size[1] = 2'd2; wdata[1] = 32'hDEADBEEF; req[1] = 1'b1;
        n = 0;
        while (!dm_we && n < 10) begin @(negedge clk); n++; end
        chk("rst_acc_seen", {31'b0, dm_we}, 32'd1);
        #1 rst = 1'b1;
        #1 chk_all_zero("rst_acc");
        we[0] = 1'b0; addr[0] = 12'h008; size[0] = 2'd2; sgn[0] = 1'b0; req[0] = 1'b1;
        #1 rst = 1'b0;
        chk("rst_nowrite", mem[2], 32'h11223344);
        n = 0;
        while (ack_v == 2'b00 && n < 10) begin @(negedge clk); n++; end
        chk("rst_first_ack", {30'b0, ack_v}, 32'd1);
        chk("rst_p0_rd", p0_rdata, 32'h11223344);
        @(posedge clk); #2;
        req[0] = 1'b0;
        n = 0;
        while (!p1_ack && n < 10) begin @(negedge clk); n++; end
        chk("rst_p1_ack", {31'b0, p1_ack}, 32'd1);
        @(posedge clk); #2;
        req[1] = 1'b0;
        chk("rst_reissue_mem", mem[2], 32'hDEADBEEF);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Two-requester controller in front of the single-port 4 KB data memory (dm_4k).
- Takes byte-addressed load/store requests from port 0 (CPU data side) and port 1 (DMA/debug side) and arbitrates between them round-robin.
- Translates size and address into the memory's word address and dmop lane code, and formats load data (lane select, sign/zero extension).
- Sits between the requesters and dm_4k; it owns the memory's address, din, we and dmop inputs.

Parameters:
- AW, 12, byte-address width; the memory word address is addr[AW-1:2].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- p0_req / p1_req  in  1  request; held high until ack.
- p0_we / p1_we  in  1  1 = store, 0 = load.
- p0_addr / p1_addr  in  AW  byte address.
- p0_size / p1_size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- p0_sgn / p1_sgn  in  1  sign-extend load data (byte and half only).
- p0_wdata / p1_wdata  in  32  store data, right-aligned.
- p0_ack / p1_ack  out  1  one-cycle completion pulse.
- p0_err / p1_err  out  1  valid with ack; access was misaligned or illegal.
- p0_rdata / p1_rdata  out  32  load result, valid with ack, held until the next ack on that port.
- dm_addr  out  AW-2  memory word address.
- dm_din  out  32  memory write data.
- dm_we  out  1  memory write enable.
- dm_dmop  out  3  lane code: 000 word, 001 half[15:0], 010 half[31:16], 011..110 byte lane 0..3.
- dm_dout  in  32  memory read data, combinational from dm_addr.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - All outputs are 0: acks, errs, rdata, dm_addr, dm_din, dm_we, dm_dmop=000.
  - Round-robin pointer last=1, so port 0 wins the first tie.
- States: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If no req, stay in IDLE.
  - If only one port is requesting, grant it.
  - If both are requesting, grant the port != last.
  - On the grant edge: latch the winner's we, addr, size, sgn and wdata; compute err; set last = winner; go to ACCESS.
- ACCESS (exactly 1 cycle):
  - dm_addr = latched addr[AW-1:2].
  - dm_din = latched wdata, unshifted (the memory takes the half from din[15:0] and the byte from din[7:0]).
  - dm_dmop encoding:
    - word -> 000.
    - half -> 001 if addr[1]=0, 010 if addr[1]=1.
    - byte -> 011 + addr[1:0].
  - dm_we = latched we & ~err. It is high only in ACCESS and is decoded from registered state (no combinational path from req).
  - On the exit edge, register rdata from dm_dout:
    - word: dm_dout.
    - half: select dm_dout[15:0] or dm_dout[31:16] by addr[1].
    - byte: select lane addr[1:0].
    - Zero- or sign-extend per sgn.
    - Stores and errored accesses give rdata = 0.
  - Go to DONE.
- DONE (1 cycle):
  - Granted port's ack = 1; err = latched err.
  - req is ignored in DONE; return to IDLE.
  - The requester must drop req by the first cycle after ack, otherwise it is taken as a new request.
- err = 1 when:
  - size = 11, or
  - size = half and addr[0] = 1, or
  - size = word and addr[1:0] != 00.
  - An errored access still passes through ACCESS, but with dm_we = 0 and no memory change.
- Latency: req seen at edge 0 -> dm_we in cycle 1 -> ack in cycle 2. Throughput is one access per 3 cycles.
- Simultaneous requests: strict alternation while both are held. A lone requester may be granted repeatedly.
- Reset in ACCESS: dm_we drops immediately; no write if rst rises before the commit edge; no ack is issued. The requester re-issues.
- Inputs change during ACCESS/DONE: no effect; only latched values are used.

Decomposition:
- Package dm_pkg:
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD.
  - dmop codes DMOP_WORD, DMOP_HLO, DMOP_HHI, DMOP_B0..DMOP_B3.
  - state enum ST_IDLE/ST_ACCESS/ST_DONE.
- Sub-module dm_lane_fmt (combinational): addr[1:0], size, sgn, dm_dout -> dmop, err, formatted rdata. The top module holds the FSM, the RR pointer and the latches.

Test Plan:
- p0 store byte A5 at 0x013 -> cycle 1: dm_addr=0x004, dm_dmop=110, dm_din[7:0]=A5, dm_we=1 -> cycle 2: p0_ack=1, p0_err=0; memory word 0x004 = A5xxxxxx with other bytes unchanged.
- p0 signed byte load at 0x013 with dm_dout=A5000000 -> p0_rdata=FFFFFFA5. Unsigned load of the same address -> 000000A5. Half load at 0x012, unsigned -> 0000A500.
- p0 and p1 both hold req from reset, re-requesting after each ack -> grants in order p0, p1, p0, p1; acks 3 cycles apart; never both acks in the same cycle.
- p1 half store at 0x005, then word load at 0x006, then size=11 -> each gives p1_ack with p1_err=1, dm_we stays 0, rdata=0.
- p1 word store 0xDEADBEEF at 0x008, rst pulsed during ACCESS before the edge -> dm_we falls immediately, no ack, word 0x002 unchanged, all outputs 0, next grant goes to p0.
